pipelined_sklansky_adder: RTL

PIPELINED_SKLANSKY_ADDER -- requirements
Module: pipelined_sklansky_adder

---
 rtl/sklansky_pkg.sv | 20 ++
 rtl/sklansky_pg_cell.sv | 15 +
 rtl/pipelined_sklansky_adder.sv | 127 ++++++++++++
 3 files changed

// File: rtl/sklansky_pkg.sv
// Shared width parameters and elaboration helpers for the Sklansky prefix adder.
// Pure constants and constant functions; no latency or flow-control behaviour.
package sklansky_pkg;

    localparam int DEFAULT_WIDTH = 32;

    function automatic bit width_is_legal(input int w);
        return (w == 8) || (w == 16) || (w == 32) || (w == 64);
    endfunction

    function automatic int log2_ceil(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/sklansky_pg_cell.sv
// Prefix node: merges a high (g,p) group with the adjacent lower group.
// Purely combinational, zero latency, no flow control.
module sklansky_pg_cell (
    input  logic gh_i,
    input  logic ph_i,
    input  logic gl_i,
    input  logic pl_i,
    output logic g_o,
    output logic p_o
);

    assign g_o = gh_i | (ph_i & gl_i);
    assign p_o = ph_i & pl_i;

endmodule

// File: rtl/pipelined_sklansky_adder.sv
// Pipelined Sklansky add/sub, latency LEVELS+2; one register per prefix level.
// Backpressure: every stage freezes while out_valid && !out_ready; in_ready mirrors advance.
module pipelined_sklansky_adder
    import sklansky_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int LEVELS = log2_ceil(WIDTH);

    if (!width_is_legal(WIDTH)) begin : g_bad_width
        $error("pipelined_sklansky_adder: WIDTH must be 8, 16, 32 or 64");
    end

    logic                         advance;
    logic [WIDTH-1:0]             b_eff;
    logic [WIDTH-1:0]             g0_d;
    logic [WIDTH-1:0]             p0_d;
    logic                         c0_d;

    logic [LEVELS:0]              v_q;
    logic [LEVELS:0]              c_q;
    logic [LEVELS:0][WIDTH-1:0]   g_q;
    logic [LEVELS:0][WIDTH-1:0]   p_q;
    logic [LEVELS:0][WIDTH-1:0]   x_q;
    logic [LEVELS-1:0][WIDTH-1:0] g_d;
    logic [LEVELS-1:0][WIDTH-1:0] p_d;

    logic [WIDTH-1:0]             carry_d;
    logic [WIDTH-1:0]             sum_d;
    logic                         cout_d;
    logic                         ovf_d;

    logic [WIDTH-1:0]             sum_q;
    logic                         cout_q;
    logic                         ovf_q;
    logic                         out_valid_q;

    assign advance  = !out_valid_q || out_ready;
    assign in_ready = advance;

    assign b_eff = sub ? ~b : b;
    assign c0_d  = sub ? 1'b1 : cin;
    assign g0_d  = a & b_eff;
    assign p0_d  = a ^ b_eff;

    // Level k: bit i with bit k set absorbs the group ending just below its 2^k-aligned block.
    for (genvar k = 0; k < LEVELS; k++) begin : g_level
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            if (((i >> k) % 2) == 1) begin : g_node
                localparam int J = ((i >> k) << k) - 1;
                sklansky_pg_cell u_cell (
                    .gh_i (g_q[k][i]),
                    .ph_i (p_q[k][i]),
                    .gl_i (g_q[k][J]),
                    .pl_i (p_q[k][J]),
                    .g_o  (g_d[k][i]),
                    .p_o  (p_d[k][i])
                );
            end else begin : g_pass
                assign g_d[k][i] = g_q[k][i];
                assign p_d[k][i] = p_q[k][i];
            end
        end
    end

    // Carry-in is applied after the tree, so group P over [i:0] is still meaningful here.
    assign carry_d = g_q[LEVELS] | (p_q[LEVELS] & {WIDTH{c_q[LEVELS]}});
    assign sum_d   = x_q[LEVELS] ^ {carry_d[WIDTH-2:0], c_q[LEVELS]};
    assign cout_d  = carry_d[WIDTH-1];
    assign ovf_d   = carry_d[WIDTH-1] ^ carry_d[WIDTH-2];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_q         <= '0;
            c_q         <= '0;
            g_q         <= '0;
            p_q         <= '0;
            x_q         <= '0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else if (advance) begin
            v_q    <= {v_q[LEVELS-1:0], in_valid};
            c_q    <= {c_q[LEVELS-1:0], c0_d};
            g_q[0] <= g0_d;
            p_q[0] <= p0_d;
            x_q[0] <= p0_d;
            for (int k = 0; k < LEVELS; k++) begin
                g_q[k+1] <= g_d[k];
                p_q[k+1] <= p_d[k];
                x_q[k+1] <= x_q[k];
            end
            sum_q       <= sum_d;
            cout_q      <= cout_d;
            ovf_q       <= ovf_d;
            out_valid_q <= v_q[LEVELS];
        end
    end

    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

    property p_hold_when_stalled;
        @(posedge clk) disable iff (rst)
        (out_valid && !out_ready) |=> (out_valid && $stable(sum) && $stable(cout) && $stable(ovf));
    endproperty
    a_hold_when_stalled: assert property (p_hold_when_stalled);

endmodule
